// File: rtl/key_entry_buffer_pkg.sv
// Shared types and parameter helpers for the key entry buffer: FSM encoding,
// BCD nibble width and the MAX_DIGITS/VALUE_W legality rule.
package key_entry_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTRY   = 2'd1,
    CONVERT = 2'd2,
    HOLD    = 2'd3
  } state_e;

  // Smallest w with 2^w >= 10^max_digits, i.e. 2^w > largest decimal entry.
  function automatic int min_value_w(input int max_digits);
    longint lim;
    int     w;
    lim = 1;
    w   = 0;
    for (int i = 0; i < max_digits; i++) lim = lim * 10;
    while ((longint'(1) << w) < lim) w++;
    return w;
  endfunction

  function automatic bit params_ok(input int max_digits, input int value_w);
    return (max_digits >= 1) && (max_digits <= 8) &&
           (value_w >= min_value_w(max_digits));
  endfunction

endpackage

// File: rtl/key_entry_buffer_if.sv
// Bundle of key event inputs, the result handshake and the display/status
// outputs of key_entry_buffer.
interface key_entry_if #(
  parameter int MAX_DIGITS = 4,
  parameter int VALUE_W    = 14
);
  import key_entry_pkg::*;

  logic [9:0]                      key_num;
  logic                            key_b;
  logic                            key_c;
  logic                            key_enter;

  // Result handshake: value_valid rises once conversion finishes and holds with
  // value stable until a cycle where value_valid && value_ready; the transfer
  // completes on that edge and value_valid drops. value_ready may be high early.
  logic                            value_ready;
  logic [VALUE_W-1:0]              value;
  logic                            value_valid;

  logic [BCD_W*MAX_DIGITS-1:0]     digits_bcd;
  logic [$clog2(MAX_DIGITS+1)-1:0] digit_count;
  logic                            busy;
  logic                            err;

  modport master (
    output key_num, key_b, key_c, key_enter, value_ready,
    input  value, value_valid, digits_bcd, digit_count, busy, err
  );

  modport slave (
    input  key_num, key_b, key_c, key_enter, value_ready,
    output value, value_valid, digits_bcd, digit_count, busy, err
  );

endinterface

// File: rtl/key_entry_buffer_digit_encoder.sv
// One-hot-10 key vector to BCD digit; multi flags anything other than exactly
// one bit set.
module digit_encoder
  import key_entry_pkg::*;
(
  input  logic [9:0]       onehot,
  output logic [BCD_W-1:0] bcd,
  output logic             multi
);

  logic [3:0] ones;

  always_comb begin
    bcd  = '0;
    ones = '0;
    for (int i = 0; i < 10; i++) begin
      if (onehot[i]) begin
        bcd  = BCD_W'(i);
        ones = ones + 4'd1;
      end
    end
    multi = (ones != 4'd1);
  end

endmodule

// File: rtl/key_entry_buffer.sv
// Decimal key entry buffer: collects digit pulses into a BCD buffer, then on
// commit converts it MSD-first to binary and offers it on a valid/ready port.
module key_entry_buffer
  import key_entry_pkg::*;
#(
  parameter int MAX_DIGITS = 4,
  parameter int VALUE_W    = 14
) (
  input  logic        clk_slow,
  input  logic        rst,
  key_entry_if.slave  bus,
  output logic [1:0]  fsm_state
);

  localparam int BUF_W = BCD_W * MAX_DIGITS;
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int IDX_W = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_ENTRY   = ENTRY;
  localparam logic [1:0] S_CONVERT = CONVERT;
  localparam logic [1:0] S_HOLD    = HOLD;

  if (!params_ok(MAX_DIGITS, VALUE_W)) begin : g_param_check
    $error("key_entry_buffer: MAX_DIGITS must be 1..8 and VALUE_W wide enough");
  end

  logic [1:0]         state_q, state_n;
  logic [BUF_W-1:0]   buf_q, buf_n, buf_shl;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic [VALUE_W-1:0] acc_q, acc_n, acc_x10;
  logic [BCD_W-1:0]   nib;
  logic               err_q, err_n;
  logic               valid_q, busy_q;

  logic [BCD_W-1:0]   key_bcd;
  logic               key_multi;
  logic               key_digit, key_any;

  digit_encoder u_digit_encoder (
    .onehot (bus.key_num),
    .bcd    (key_bcd),
    .multi  (key_multi)
  );

  assign key_digit = |bus.key_num;
  assign key_any   = key_digit | bus.key_b | bus.key_c | bus.key_enter;
  assign buf_shl   = (buf_q << BCD_W) | BUF_W'(key_bcd);
  assign nib       = buf_q[idx_q*BCD_W +: BCD_W];
  assign acc_x10   = (acc_q << 3) + (acc_q << 1);

  always_comb begin
    state_n = state_q;
    buf_n   = buf_q;
    cnt_n   = cnt_q;
    idx_n   = idx_q;
    acc_n   = acc_q;
    err_n   = 1'b0;
    case (state_q)
      S_IDLE, S_ENTRY: begin
        // Only the highest-priority event acts: clear > enter > backspace > digit.
        if (bus.key_c) begin
          buf_n   = '0;
          cnt_n   = '0;
          state_n = S_IDLE;
        end else if (bus.key_enter) begin
          if (cnt_q == '0) begin
            err_n = 1'b1;
          end else begin
            acc_n   = '0;
            idx_n   = IDX_W'(cnt_q - CNT_W'(1));
            state_n = S_CONVERT;
          end
        end else if (bus.key_b) begin
          if (cnt_q == '0) begin
            err_n = 1'b1;
          end else begin
            buf_n   = buf_q >> BCD_W;
            cnt_n   = cnt_q - CNT_W'(1);
            state_n = (cnt_q == CNT_W'(1)) ? S_IDLE : S_ENTRY;
          end
        end else if (key_digit) begin
          if (key_multi || (cnt_q == CNT_W'(MAX_DIGITS))) begin
            err_n = 1'b1;
          end else begin
            buf_n   = buf_shl;
            cnt_n   = cnt_q + CNT_W'(1);
            state_n = S_ENTRY;
          end
        end
      end
      S_CONVERT: begin
        if (bus.key_c) begin
          buf_n   = '0;
          cnt_n   = '0;
          state_n = S_IDLE;
        end else begin
          acc_n = acc_x10 + VALUE_W'(nib);
          if (idx_q == '0) state_n = S_HOLD;
          else             idx_n   = idx_q - IDX_W'(1);
        end
      end
      S_HOLD: begin
        // Keys are refused here even when the handshake completes this cycle.
        err_n = key_any;
        if (valid_q && bus.value_ready) begin
          buf_n   = '0;
          cnt_n   = '0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_slow or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      buf_q   <= buf_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      acc_q   <= acc_n;
      err_q   <= err_n;
      valid_q <= (state_n == S_HOLD);
      busy_q  <= (state_n == S_CONVERT) || (state_n == S_HOLD);
    end
  end

  assign bus.value       = acc_q;
  assign bus.value_valid = valid_q;
  assign bus.digits_bcd  = buf_q;
  assign bus.digit_count = cnt_q;
  assign bus.busy        = busy_q;
  assign bus.err         = err_q;
  assign fsm_state       = state_q;

endmodule

// File: tb/tb_key_entry_buffer.sv
// Directed bench for key_entry_buffer: digit entry, backspace, clear, commit,
// result handshake, error pulses, abort and asynchronous reset.
module tb_key_entry_buffer;

  localparam int MAX_DIGITS = 4;
  localparam int VALUE_W    = 14;

  logic       clk_slow;
  logic       rst;
  logic [1:0] fsm_state;

  int checks   = 0;
  int failures = 0;

  key_entry_if #(.MAX_DIGITS(MAX_DIGITS), .VALUE_W(VALUE_W)) bus ();

  key_entry_buffer #(.MAX_DIGITS(MAX_DIGITS), .VALUE_W(VALUE_W)) dut (
    .clk_slow  (clk_slow),
    .rst       (rst),
    .bus       (bus.slave),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk_slow = 1'b0;
  always #5 clk_slow = ~clk_slow;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk_slow);
    #1;
  endtask

  task automatic press(input logic [9:0] num, input logic b, input logic c, input logic e);
    bus.key_num   = num;
    bus.key_b     = b;
    bus.key_c     = c;
    bus.key_enter = e;
    step();
    bus.key_num   = '0;
    bus.key_b     = 1'b0;
    bus.key_c     = 1'b0;
    bus.key_enter = 1'b0;
  endtask

  task automatic digit(input int d);
    press(10'(1) << d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 64'(fsm_state), 64'd0);
    chk({tag, "_value"}, 64'(bus.value), 64'd0);
    chk({tag, "_valid"}, 64'(bus.value_valid), 64'd0);
    chk({tag, "_bcd"},   64'(bus.digits_bcd), 64'd0);
    chk({tag, "_count"}, 64'(bus.digit_count), 64'd0);
    chk({tag, "_busy"},  64'(bus.busy), 64'd0);
    chk({tag, "_err"},   64'(bus.err), 64'd0);
  endtask

  initial begin
    rst             = 1'b0;
    bus.key_num     = '0;
    bus.key_b       = 1'b0;
    bus.key_c       = 1'b0;
    bus.key_enter   = 1'b0;
    bus.value_ready = 1'b0;
    repeat (3) step();
    chk_reset_vals("reset");
    rst = 1'b1;
    step();

    // 1,2,3,4 enter with ready already high: valid for exactly one cycle
    digit(1); digit(2); digit(3); digit(4);
    chk("t1_bcd", 64'(bus.digits_bcd), 64'h1234);
    chk("t1_count", 64'(bus.digit_count), 64'd4);
    bus.value_ready = 1'b1;
    press('0, 1'b0, 1'b0, 1'b1);
    chk("t1_state_conv", 64'(fsm_state), 64'd2);
    chk("t1_busy", 64'(bus.busy), 64'd1);
    repeat (3) step();
    chk("t1_valid_early", 64'(bus.value_valid), 64'd0);
    step();
    chk("t1_valid", 64'(bus.value_valid), 64'd1);
    chk("t1_value", 64'(bus.value), 64'd1234);
    step();
    chk("t1_valid_drop", 64'(bus.value_valid), 64'd0);
    chk("t1_count_after", 64'(bus.digit_count), 64'd0);
    chk("t1_state_idle", 64'(fsm_state), 64'd0);
    bus.value_ready = 1'b0;

    // 9,8, backspace, 7 -> 97
    digit(9); digit(8);
    chk("t2_bcd98", 64'(bus.digits_bcd), 64'h98);
    press('0, 1'b1, 1'b0, 1'b0);
    chk("t2_bcd_bs", 64'(bus.digits_bcd), 64'h9);
    chk("t2_count_bs", 64'(bus.digit_count), 64'd1);
    digit(7);
    chk("t2_bcd97", 64'(bus.digits_bcd[7:0]), 64'h97);
    bus.value_ready = 1'b1;
    press('0, 1'b0, 1'b0, 1'b1);
    repeat (2) step();
    chk("t2_valid", 64'(bus.value_valid), 64'd1);
    chk("t2_value", 64'(bus.value), 64'd97);
    step();
    chk("t2_valid_drop", 64'(bus.value_valid), 64'd0);
    bus.value_ready = 1'b0;

    // five digits: fifth rejected; long hold with ready low
    digit(1); digit(2); digit(3); digit(4);
    chk("t3_err_before", 64'(bus.err), 64'd0);
    digit(5);
    chk("t3_err_full", 64'(bus.err), 64'd1);
    chk("t3_bcd_full", 64'(bus.digits_bcd), 64'h1234);
    chk("t3_count_full", 64'(bus.digit_count), 64'd4);
    step();
    chk("t3_err_pulse", 64'(bus.err), 64'd0);
    press('0, 1'b0, 1'b0, 1'b1);
    repeat (4) step();
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold_valid", 64'(bus.value_valid), 64'd1);
      chk("t3_hold_value", 64'(bus.value), 64'd1234);
      step();
    end
    digit(5);
    chk("t3_hold_key_err", 64'(bus.err), 64'd1);
    chk("t3_hold_key_valid", 64'(bus.value_valid), 64'd1);
    press('0, 1'b0, 1'b1, 1'b0);
    chk("t3_hold_clr_err", 64'(bus.err), 64'd1);
    chk("t3_hold_clr_state", 64'(fsm_state), 64'd3);
    chk("t3_hold_clr_value", 64'(bus.value), 64'd1234);
    // handshake and a digit in the same cycle: digit dropped with err
    bus.value_ready = 1'b1;
    digit(3);
    chk("t3_hs_err", 64'(bus.err), 64'd1);
    chk("t3_hs_valid", 64'(bus.value_valid), 64'd0);
    chk("t3_hs_count", 64'(bus.digit_count), 64'd0);
    chk("t3_hs_bcd", 64'(bus.digits_bcd), 64'd0);
    chk("t3_hs_busy", 64'(bus.busy), 64'd0);
    bus.value_ready = 1'b0;

    // rejected events in IDLE, multi-bit digit
    press('0, 1'b0, 1'b0, 1'b1);
    chk("t4_enter_empty_err", 64'(bus.err), 64'd1);
    chk("t4_enter_empty_state", 64'(fsm_state), 64'd0);
    press('0, 1'b1, 1'b0, 1'b0);
    chk("t4_bs_idle_err", 64'(bus.err), 64'd1);
    chk("t4_bs_idle_count", 64'(bus.digit_count), 64'd0);
    press('0, 1'b0, 1'b1, 1'b0);
    chk("t4_clr_idle_err", 64'(bus.err), 64'd0);
    digit(6);
    press(10'b0000000101, 1'b0, 1'b0, 1'b0);
    chk("t4_multi_err", 64'(bus.err), 64'd1);
    chk("t4_multi_bcd", 64'(bus.digits_bcd), 64'h6);
    chk("t4_multi_count", 64'(bus.digit_count), 64'd1);
    press('0, 1'b1, 1'b0, 1'b0);
    chk("t4_bs_to_idle", 64'(fsm_state), 64'd0);
    chk("t4_bs_err", 64'(bus.err), 64'd0);

    // leading zeros
    digit(0); digit(0); digit(7);
    chk("t5_bcd007", 64'(bus.digits_bcd), 64'h007);
    chk("t5_count", 64'(bus.digit_count), 64'd3);
    bus.value_ready = 1'b1;
    press('0, 1'b0, 1'b0, 1'b1);
    repeat (3) step();
    chk("t5_valid", 64'(bus.value_valid), 64'd1);
    chk("t5_value", 64'(bus.value), 64'd7);
    step();
    bus.value_ready = 1'b0;

    // abort with key_c on the second CONVERT cycle
    digit(9); digit(9); digit(9); digit(9);
    press('0, 1'b0, 1'b0, 1'b1);
    step();
    press('0, 1'b0, 1'b1, 1'b0);
    chk("t6_abort_busy", 64'(bus.busy), 64'd0);
    chk("t6_abort_count", 64'(bus.digit_count), 64'd0);
    chk("t6_abort_bcd", 64'(bus.digits_bcd), 64'd0);
    chk("t6_abort_state", 64'(fsm_state), 64'd0);
    chk("t6_abort_err", 64'(bus.err), 64'd0);
    for (int i = 0; i < 5; i++) begin
      chk("t6_no_valid", 64'(bus.value_valid), 64'd0);
      step();
    end

    // digit and clear in the same cycle
    digit(1); digit(2);
    press(10'(1) << 5, 1'b0, 1'b1, 1'b0);
    chk("t7_clr_bcd", 64'(bus.digits_bcd), 64'd0);
    chk("t7_clr_count", 64'(bus.digit_count), 64'd0);
    chk("t7_clr_err", 64'(bus.err), 64'd0);

    // async reset while holding a result
    digit(4); digit(2);
    press('0, 1'b0, 1'b0, 1'b1);
    repeat (2) step();
    chk("t8_valid", 64'(bus.value_valid), 64'd1);
    chk("t8_value", 64'(bus.value), 64'd42);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_vals("t8_async");
    step();
    rst = 1'b1;
    step();
    chk("t8_after_state", 64'(fsm_state), 64'd0);
    chk("t8_after_valid", 64'(bus.value_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_entry_buffer.md
# key_entry_buffer

Consumes the single-cycle key event pulses from the PS/2 keyboard front end and assembles digit presses into a multi-digit decimal number. The block supports backspace (`key_b`), clear (`key_c`) and commit (`key_enter`). On commit it converts the BCD buffer to binary serially and presents the result on a valid/ready handshake to game/control logic. The live BCD buffer is also exported for seven-segment display.

## Interface
- `MAX_DIGITS`, default 4: buffer depth in decimal digits, legal range 1–8.
- `VALUE_W`, default 14: result width. Must satisfy 2^VALUE_W > 10^MAX_DIGITS − 1.
- `clk_slow` input 1: clock; all inputs are sampled here.
- `rst` input 1: reset, asynchronous, active-low.
- `key_num` input 10: digit event pulses, bit i = key "i"; each is one cycle wide.
- `key_b` input 1: backspace pulse.
- `key_c` input 1: clear pulse.
- `key_enter` input 1: commit pulse.
- `value_ready` input 1: consumer accepts `value`.
- `value` output VALUE_W: converted binary number; stable while `value_valid` is high.
- `value_valid` output 1: result available.
- `digits_bcd` output 4*MAX_DIGITS: buffer contents; nibble 0 holds the most recent digit; unused nibbles read 0.
- `digit_count` output $clog2(MAX_DIGITS+1): number of digits currently held.
- `busy` output 1: high in CONVERT and HOLD.
- `err` output 1: one-cycle pulse on any rejected event.

## Operation
- States: IDLE (count=0), ENTRY (count≥1), CONVERT, HOLD.
- Per-cycle event priority in IDLE/ENTRY: `key_c` > `key_enter` > `key_b` > digit. Only the highest-priority event present acts; lower ones are dropped silently.
- **Digit:**
  - Valid only if exactly one `key_num` bit is set.
  - If count<MAX_DIGITS: buffer shifts left one nibble, the new digit enters nibble 0, count+1, state becomes ENTRY.
  - If count==MAX_DIGITS: ignored, `err` pulses.
  - More than one `key_num` bit set: ignored, `err` pulses.
- **Backspace:** if count>0, buffer shifts right one nibble (top nibble becomes 0) and count−1. Reaching count 0 returns to IDLE. In IDLE, `err` pulses.
- **Clear:** buffer becomes 0, count 0, state IDLE. In IDLE it is a no-op with no `err`.
- **Enter:**
  - count==0: ignored, `err` pulses.
  - Otherwise: acc←0, digit index←count−1, state CONVERT.
- **CONVERT:** one digit per cycle, most significant first: acc ← acc*10 + nibble[index].
  - acc*10 is implemented as (acc<<3)+(acc<<1), truncated to VALUE_W; no overflow is possible when the VALUE_W rule holds.
  - After index 0 is processed, state becomes HOLD.
  - `key_c` in CONVERT aborts: clear, state IDLE, `value_valid` never asserted.
  - All other keys in CONVERT are ignored, with no `err`.
- **HOLD:**
  - `value_valid`=1 and `value`=acc.
  - All key events are ignored, including `key_c`; each ignored event pulses `err`.
  - On `value_valid && value_ready`: buffer is cleared, count 0, state IDLE, and `value_valid` drops on the next edge.
- Leading zeros are legal: "007" yields 7.

## Timing
- Reset values: state IDLE, `value`=0, `value_valid`=0, `digits_bcd`=0, `digit_count`=0, `busy`=0, `err`=0.
- Every output is registered.
- `digits_bcd`/`digit_count` update on the edge that samples the event.
- Conversion latency:
  - Enter sampled at edge k → CONVERT from edge k.
  - `value_valid` is high after edge k+count; for 4 digits, 4 cycles after the enter edge.
- `value_valid` stays high and `value` stays stable until a handshake; `value_ready` is not required to be low before valid.
- A handshake and a new key in the same cycle: the key is dropped with `err`, because the block is still in HOLD.
- Async reset mid-CONVERT/HOLD forces the reset state immediately; a pending result is discarded.

## Structure
- Package `key_entry_pkg`: state enum (IDLE, ENTRY, CONVERT, HOLD), `BCD_W`=4, a function computing the minimum VALUE_W from MAX_DIGITS, and the elaboration-time legality check.
- Sub-module `digit_encoder`: combinational one-hot-10 → 4-bit BCD, plus a `multi` flag for zero or more than one bit set. This is the only natural split; the FSM, buffer and MAC stay in the top module.

## Test plan
- Keys 1,2,3,4 then enter, `value_ready`=1 → `value`=1234 (0x4D2); `value_valid` high after 4 cycles for exactly one cycle; then `digit_count`=0.
- Keys 9,8 then backspace, then 7, enter → `digits_bcd` low byte 0x97 before enter; `value`=97.
- 5 digits 1..5 entered → fifth press gives `err` pulse, `digits_bcd`=0x1234; enter, then `value_ready` held low 10 cycles → `value_valid` and `value`=1234 stable throughout; any key during the hold → `err`.
- Enter with empty buffer, and backspace in IDLE → `err` pulses, state unchanged; `key_num`=10'b0000000101 → `err`, buffer unchanged.
- Keys 9,9,9,9, enter, `key_c` asserted on the second CONVERT cycle → no `value_valid`; `digit_count`=0; `busy` low the next cycle.
- Digit and `key_c` in the same cycle → buffer cleared, digit dropped; assert `rst` low while in HOLD → all outputs at reset values immediately.
